mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front end that sits directly upstream of the word-addressed, big-endian data memory `M`. It accepts byte, halfword and word requests over a valid/ready handshake. It turns each request into whole-word `M` reads and writes, using read-modify-write for sub-word stores. Loaded data is returned with zero- or sign-extension, and misaligned or illegal requests are rejected without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; `M` consumes bits `[MemAddrWidth+1:2]`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on a cycle where valid and ready are both 1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response strobe; no backpressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal request; valid with `rsp_valid`.
- `mem_addr`  out  ADDR_W  to `M` addr; always `{addr[ADDR_W-1:2],2'b00}` when active.
- `mem_read`  out  1  to `M` read enable.
- `mem_write`  out  1  to `M` write enable; `M` commits on the rising edge.
- `mem_wdata`  out  32  to `M` write value.
- `mem_rdata`  in  32  from `M`; combinational read of the addressed word.

## Operation
- FSM states: IDLE, RD, WR, RSP. The request fields are latched on accept.
- IDLE:
  - `req_ready`=1.
  - On accept:
    - Illegal size, half with addr[0]=1, or word with addr[1:0]≠0 → RSP with err=1.
    - Load → RD.
    - Word store → WR.
    - Byte/half store → RD.
- RD:
  - `mem_read`=1.
  - `mem_rdata` is captured into the word register on the edge.
  - Next state: load → RSP; sub-word store → WR.
- WR:
  - `mem_write`=1.
  - `mem_wdata` = merged word for sub-word stores; `req_wdata` for word stores.
  - Next state: RSP.
- RSP:
  - `rsp_valid`=1 for exactly one cycle, then IDLE.
- Byte ordering is big-endian. Byte offset k occupies word bits `[31-8k -: 8]`. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Load extraction: select the lane above, then extend to 32 bits per `req_signed`. Word loads pass through unchanged.
- Store merge: replace only the selected lane with `req_wdata[7:0]` or `[15:0]`; all other bytes keep the value read in RD.
- Outside RD/WR: `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- `rsp_rdata`/`rsp_err` are registered, held from RSP until the next RSP, and cleared only by reset.

## Timing
- Accept at cycle 0. `rsp_valid` is asserted at:
  - load: cycle 2;
  - sub-word store: cycle 3;
  - word store: cycle 2;
  - error: cycle 1.
- Throughput: the next request can be accepted in the cycle after RSP. `req_ready`=0 in RD, WR and RSP.
- Memory commit: a store's bytes are visible in `M` from the cycle after WR. A following load sees them.
- Memory outputs are decoded from the state register. They change only after clock edges or async reset, never combinationally from `req_*`.
- Reset (`rst_n`=0), effective immediately and asynchronously:
  - state=IDLE;
  - `req_ready`=0 while reset is held;
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0;
  - all `mem_*` outputs = 0.
- Reset mid-operation: the in-flight request is dropped with no response. Reset asserted during WR drops `mem_write` before the next edge, so memory is unchanged.
- After `rst_n` rises: `req_ready`=1 from the first cycle.
- `req_*` changes while `req_ready`=0 are ignored.

## Test plan
- Word 0x10 = 0x11223344. Load byte unsigned @0x12 → `mem_read` @cycle 1 with `mem_addr`=0x10; `rsp_rdata`=0x00000033, err=0 @cycle 2.
- Word 0x20 = 0x80FF1234:
  - signed half @0x20 → 0xFFFF80FF;
  - signed byte @0x21 → 0xFFFFFFFF;
  - unsigned half @0x22 → 0x00001234.
- Store byte 0xAB @0x11 over 0x11223344 → RD @cycle 1, WR @cycle 2 with `mem_wdata`=0x11AB3344, rsp @cycle 3. A later word load @0x10 returns 0x11AB3344.
- Word load @0x13, half store @0x21, size=11 → each gives `rsp_err`=1 @cycle 1 with `mem_read`/`mem_write` never asserted. Memory is unchanged.
- `req_valid` held high with 3 queued requests (load, word store 0xDEADBEEF @0x30, load @0x30):
  - `req_ready` low while busy;
  - accepts spaced load 3 / store 2 cycles apart;
  - final load returns 0xDEADBEEF.
- Sub-word store with `rst_n` pulsed low during WR → `mem_write` falls within the cycle and the word is unchanged. No `rsp_valid`. `req_ready`=1 the first cycle after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-addressed, big-endian
// data memory. Sub-word stores use read-modify-write; loads are extracted
// from the addressed lane and zero/sign-extended. Bad requests are answered
// with an error response without any memory access.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_req_err;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;

    // Pick the big-endian lane selected by size/offset and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overwrite only the selected lane of the previously read word.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off,
                                            input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    m[31:24] = wd[7:0];
                    2'd1:    m[23:16] = wd[7:0];
                    2'd2:    m[15:8]  = wd[7:0];
                    default: m[7:0]   = wd[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) m[15:0]  = wd[15:0];
                else        m[31:16] = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign w_accept  = req_valid & req_ready;
    assign w_req_err = (req_size == SZ_ILL)
                     | ((req_size == SZ_HALF) & req_addr[0])
                     | ((req_size == SZ_WORD) & (|req_addr[1:0]));
    assign w_merged  = f_merge(r_word, r_size, r_addr[1:0], r_wdata);
    assign w_load    = f_extract(mem_rdata, r_size, r_addr[1:0], r_signed);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)                 w_next = S_RSP;
                    else if (!req_write)           w_next = S_RD;
                    else if (req_size == SZ_WORD)  w_next = S_WR;
                    else                           w_next = S_RD;
                end
            end
            S_RD:    w_next = r_write ? S_WR : S_RSP;
            S_WR:    w_next = S_RSP;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only (plus reset for ready)
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: req_ready = rst_n;
            S_RD: begin
                mem_read = 1'b1;
                mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            end
            S_WR: begin
                mem_write = 1'b1;
                mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                mem_wdata = (r_size == SZ_WORD) ? r_wdata : w_merged;
            end
            default: rsp_valid = 1'b1;
        endcase
    end

    // Request latch on accept and word capture during RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == S_RD) r_word <= mem_rdata;
        end
    end

    // Response registers: loaded on the edge into RSP, held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE && w_accept && w_req_err) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end else if (r_state == S_RD && !r_write) begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
        end else if (r_state == S_WR) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        preload;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h11223344;
            mem[8] <= 32'h80FF1234;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (called just after a rising edge with the DUT idle)
    // and record when memory strobes and the response appear.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output int rd_cyc, output int wr_cyc,
                           output logic [31:0] rd_addr, output logic [31:0] wr_data,
                           output logic [31:0] rdata, output logic err);
        lat = -1; rd_cyc = -1; wr_cyc = -1;
        rd_addr = '0; wr_data = '0; rdata = '0; err = 1'b0;
        req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (mem_read  && rd_cyc < 0) begin rd_cyc = c; rd_addr = mem_addr; end
            if (mem_write && wr_cyc < 0) begin wr_cyc = c; wr_data = mem_wdata; end
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    int          lat, rdc, wrc;
    logic [31:0] rda, wrd, rd;
    logic        er;
    int          acc [0:2];
    int          nacc, nrsp, rdy_hi;
    logic        rdy_s;
    logic [31:0] last_rd;

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        #2;
        chk("rst_ready",  {31'b0, req_ready}, 32'd0);
        chk("rst_rspv",   {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata",  rsp_rdata, 32'd0);
        chk("rst_memrw",  {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_maddr",  mem_addr, 32'd0);

        @(posedge clk); #1; preload = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // byte load unsigned @0x12 from 0x11223344
        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lb_lat",   lat, 32'd2);
        chk("lb_rdcyc", rdc, 32'd1);
        chk("lb_raddr", rda, 32'h10);
        chk("lb_nowr",  wrc, -32'sd1);
        chk("lb_data",  rd, 32'h00000033);
        chk("lb_err",   {31'b0, er}, 32'd0);
        chk("lb_hold",  rsp_rdata, 32'h00000033);

        // extraction / extension from 0x80FF1234
        run_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lh_s0", rd, 32'hFFFF80FF);
        run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lb_s1", rd, 32'hFFFFFFFF);
        run_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lb_u1", rd, 32'h000000FF);
        run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lh_u2", rd, 32'h00001234);
        run_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("lw_20", rd, 32'h80FF1234);
        chk("lw_lat", lat, 32'd2);

        // byte store 0xAB @0x11 (read-modify-write)
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, lat, rdc, wrc, rda, wrd, rd, er);
        chk("sb_rdcyc", rdc, 32'd1);
        chk("sb_wrcyc", wrc, 32'd2);
        chk("sb_wdata", wrd, 32'h11AB3344);
        chk("sb_lat",   lat, 32'd3);
        chk("sb_rdata", rd, 32'h0);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("sb_readback", rd, 32'h11AB3344);

        // half store 0xCAFE @0x22 over 0x80FF1234
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234CAFE, lat, rdc, wrc, rda, wrd, rd, er);
        chk("sh_wdata", wrd, 32'h80FFCAFE);
        chk("sh_mem",   mem[8], 32'h80FFCAFE);

        // error requests: no memory access, response at cycle 1
        run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("e_lw_lat", lat, 32'd1);
        chk("e_lw_err", {31'b0, er}, 32'd1);
        chk("e_lw_mem", rdc + wrc, -32'sd2);
        chk("e_lw_err_hold", {31'b0, rsp_err}, 32'd1);
        run_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h5555, lat, rdc, wrc, rda, wrd, rd, er);
        chk("e_sh_lat", lat, 32'd1);
        chk("e_sh_err", {31'b0, er}, 32'd1);
        chk("e_sh_mem", rdc + wrc, -32'sd2);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, rda, wrd, rd, er);
        chk("e_sz_lat", lat, 32'd1);
        chk("e_sz_err", {31'b0, er}, 32'd1);
        chk("e_sz_data", rd, 32'h0);
        chk("e_sz_mem", rdc + wrc, -32'sd2);
        chk("e_memkeep", mem[8], 32'h80FFCAFE);

        // back-to-back requests with req_valid held high
        nacc = 0; nrsp = 0; rdy_hi = 0; last_rd = '0;
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = '0; req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rdy_s = req_ready;
            if (rdy_s && c <= 8) rdy_hi++;
            if (rsp_valid) begin nrsp++; last_rd = rsp_rdata; end
            @(posedge clk);
            #1;
            if (rdy_s && req_valid) begin
                acc[nacc] = c;
                nacc++;
                if (nacc == 1) begin
                    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
                end else if (nacc == 2) begin
                    req_write = 1'b0; req_addr = 32'h30; req_wdata = '0;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("q_nacc",  nacc, 32'd3);
        chk("q_acc1",  acc[1], 32'd3);
        chk("q_acc2",  acc[2], 32'd6);
        chk("q_ready", rdy_hi, 32'd3);
        chk("q_nrsp",  nrsp, 32'd3);
        chk("q_final", last_rd, 32'hDEADBEEF);

        // reset pulsed during WR of a byte store
        @(posedge clk); #1;
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_wr_on",  {31'b0, mem_write}, 32'd1);
        chk("r_wdata",  mem_wdata, 32'h77AB3344);
        #1 rst_n = 1'b0;
        #1;
        chk("r_wr_off", {31'b0, mem_write}, 32'd0);
        chk("r_maddr",  mem_addr, 32'd0);
        chk("r_ready",  {31'b0, req_ready}, 32'd0);
        chk("r_rdata",  rsp_rdata, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        nrsp = 0;
        @(negedge clk);
        chk("r_ready_rel", {31'b0, req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) nrsp++;
            @(negedge clk);
        end
        chk("r_norsp", nrsp, 32'd0);
        chk("r_memkeep", mem[4], 32'h11AB3344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
